// File: rtl/hamming_secded_dec_pipe.sv
// Pipelined SECDED Hamming decoder with valid/ready on both sides.
//
// Codeword layout: positions 1..DW+PW. Check bit k sits at position 2^k.
// Data bit j sits at the j-th non-power-of-two position, in ascending order.
// An extra overall even-parity bit covers the whole codeword.
//
// Pipeline:
//   S1 registers the received data, the syndrome and the overall parity.
//   S2 registers the corrected data and the CE/UE classification.
// Two saturating counters record CE and UE beats as they enter S2.
//
// Ports:
//   i_clk, i_rst_n      clock; synchronous active-low reset
//   i_valid, o_ready    input handshake (o_ready is combinational from i_ready)
//   i_data              received data bits
//   i_parity            received check bits (bit k = position 2^k)
//   i_par_all           received overall parity bit
//   o_valid, i_ready    output handshake
//   o_data              corrected data
//   o_err_pos           syndrome (1-based codeword position, 0 = none)
//   o_ce, o_ue          corrected / uncorrectable error flags
//   i_cnt_clr           synchronous clear of both counters
//   o_cnt_ce, o_cnt_ue  saturating CE / UE beat counters
module hamming_secded_dec_pipe #(
  parameter int unsigned DW    = 8,
  parameter int unsigned PW    = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DW-1:0]    i_data,
  input  logic [PW-1:0]    i_parity,
  input  logic             i_par_all,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DW-1:0]    o_data,
  output logic [PW-1:0]    o_err_pos,
  output logic             o_ce,
  output logic             o_ue,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_cnt_ce,
  output logic [CNT_W-1:0] o_cnt_ue
);

  localparam int unsigned NPOS = DW + PW;

  // Codeword position of data bit j: the j-th non-power-of-two position.
  function automatic logic [PW-1:0] data_pos(input int unsigned j);
    logic [PW-1:0] res;
    int unsigned   cnt;
    res = '0;
    cnt = 0;
    for (int unsigned p = 1; p <= NPOS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == j) res = PW'(p);
        cnt++;
      end
    end
    return res;
  endfunction

  logic            s1_v;
  logic [DW-1:0]   s1_data;
  logic [PW-1:0]   s1_syn;
  logic            s1_par;

  logic            en1;
  logic            en2;
  logic            load2;

  logic [PW-1:0]   syn_c;
  logic            par_c;
  logic [DW-1:0]   fix_c;
  logic            ce_c;
  logic            ue_c;

  // Flow control: a stage may load when it is empty or its successor moves.
  assign en2     = !o_valid || i_ready;
  assign en1     = !s1_v || en2;
  assign o_ready = en1;
  assign load2   = en2 && s1_v;

  // Syndrome and overall parity of the incoming beat.
  // Check bit k contributes 2^k, so the check bits alone XOR to i_parity.
  always_comb begin
    syn_c = i_parity;
    for (int unsigned j = 0; j < DW; j++) begin
      if (i_data[j]) syn_c = syn_c ^ data_pos(j);
    end
    par_c = ^{i_data, i_parity, i_par_all};
  end

  // Stage 1 register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_syn  <= '0;
      s1_par  <= 1'b0;
    end else if (en1) begin
      s1_v    <= i_valid;
      s1_data <= i_data;
      s1_syn  <= syn_c;
      s1_par  <= par_c;
    end
  end

  // Classification and correction of the S1 beat.
  // Check-bit and zero syndromes never match a data position, so only a
  // data-position syndrome flips a bit.
  always_comb begin
    fix_c = s1_data;
    ce_c  = 1'b0;
    ue_c  = 1'b0;
    if (s1_par) begin
      if (s1_syn > PW'(NPOS)) begin
        ue_c = 1'b1;
      end else begin
        ce_c = 1'b1;
        for (int unsigned j = 0; j < DW; j++) begin
          if (data_pos(j) == s1_syn) fix_c[j] = ~fix_c[j];
        end
      end
    end else if (s1_syn != '0) begin
      ue_c = 1'b1;
    end
  end

  // Stage 2 register (output stage); holds while stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_err_pos <= '0;
      o_ce      <= 1'b0;
      o_ue      <= 1'b0;
    end else if (en2) begin
      o_valid <= s1_v;
      if (s1_v) begin
        o_data    <= fix_c;
        o_err_pos <= s1_syn;
        o_ce      <= ce_c;
        o_ue      <= ue_c;
      end else begin
        o_ce <= 1'b0;
        o_ue <= 1'b0;
      end
    end
  end

  // Saturating error counters; clear wins over a same-cycle increment.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_cnt_clr) begin
      o_cnt_ce <= '0;
      o_cnt_ue <= '0;
    end else begin
      if (load2 && ce_c && !(&o_cnt_ce)) o_cnt_ce <= o_cnt_ce + CNT_W'(1);
      if (load2 && ue_c && !(&o_cnt_ue)) o_cnt_ue <= o_cnt_ue + CNT_W'(1);
    end
  end

endmodule

// File: doc/hamming_secded_dec_pipe.md
Name: hamming_secded_dec_pipe

Overview:
- Pipelined SECDED (single-error-correct, double-error-detect) Hamming decoder with valid/ready streaming on both sides.
- Generalises the plain Hamming decoder in three ways: an overall parity bit for double-error detection, a 2-stage pipeline with backpressure, and saturating corrected/uncorrectable error counters.
- Sits on the read-return path of on-chip NPU buffers, between SRAM read data and the consumer.

Parameters:
- DW, 8, data width in bits.
- PW, 4, Hamming check-bit count. Legal only when 2^PW >= DW+PW+1.
- CNT_W, 16, width of each error counter.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_valid  input  1  input beat valid.
- o_ready  output  1  decoder can accept an input beat.
- i_data  input  DW  received data bits.
- i_parity  input  PW  received check bits; bit k sits at codeword position 2^k.
- i_par_all  input  1  received overall parity bit (even parity over data, check bits and itself).
- o_valid  output  1  output beat valid.
- i_ready  input  1  consumer accepts output beat.
- o_data  output  DW  corrected data.
- o_err_pos  output  PW  syndrome (1-based codeword position; 0 = none).
- o_ce  output  1  beat had a corrected or correctable single error.
- o_ue  output  1  beat had an uncorrectable error.
- i_cnt_clr  input  1  synchronous clear of both counters.
- o_cnt_ce  output  CNT_W  saturating count of CE beats.
- o_cnt_ue  output  CNT_W  saturating count of UE beats.

Behaviour:
- Codeword layout:
  - Positions 1..DW+PW.
  - Check bit k is at position 2^k.
  - Data bit j is at the j-th non-power-of-two position, ascending (DW=8: 3,5,6,7,9,10,11,12).
- Stage 1 (S1) registers i_data, syndrome s and overall parity p:
  - s = XOR of the positions of all set data and check bits.
  - p = XOR of all data bits, all check bits and i_par_all.
- Stage 2 (S2) registers o_data, o_err_pos=s, o_ce and o_ue, classified as:
  - s=0, p=0: clean; data passes; ce=0, ue=0.
  - p=1, s=0: overall parity bit in error; data unchanged; ce=1.
  - p=1, s=a data position: flip that data bit; ce=1.
  - p=1, s=a check position: data unchanged; ce=1.
  - p=1, s>DW+PW: invalid syndrome; ue=1; data passes uncorrected.
  - p=0, s!=0: double error; ue=1; data passes uncorrected.
- ce and ue are never both 1.
- Flow control:
  - en2 = !s2_v | i_ready.
  - en1 = !s1_v | en2.
  - o_ready = en1; combinational from i_ready, and this is intentional.
  - Input accepted when i_valid & o_ready.
  - S1 loads when en1. S2 loads S1 contents when en2.
  - Bubbles collapse: S1 always refills when empty.
- Latency:
  - Accepted beat appears on o_valid 2 cycles later when i_ready is held high.
  - Full throughput of 1 beat per cycle.
- Stall behaviour:
  - While o_valid & !i_ready, all S2 outputs hold stable.
  - No beat is dropped or duplicated.
  - Order is preserved.
- Counters:
  - Increment once per beat when it is loaded into S2 (en2 & s1_v) with ce or ue respectively.
  - Saturate at all-ones; no wrap.
  - i_cnt_clr forces 0 next cycle. Clear wins over a same-cycle increment.
- Reset (i_rst_n=0 at a clock edge):
  - s1_v=0, o_valid=0, o_data=0, o_err_pos=0, o_ce=0, o_ue=0, o_cnt_ce=0, o_cnt_ue=0.
  - o_ready=1 from the first cycle after reset.
  - Reset mid-stream discards in-flight beats and their counter updates.
- Non-valid beats never affect counters or flags.

Test Plan:
- DW=8, PW=4 clean beat: i_data=0x00, i_parity=0, i_par_all=0, i_ready=1 -> 2 cycles later o_valid=1, o_data=0x00, o_err_pos=0, o_ce=0, o_ue=0; counters unchanged.
- Single data error: i_data=0x04 (position 6), parity 0, par_all 0 -> o_data=0x00, o_err_pos=6, o_ce=1; o_cnt_ce=1.
- Parity-only and invalid syndrome:
  - i_par_all=1, all else 0 -> o_ce=1, o_err_pos=0, o_data=0x00.
  - i_parity=4'b1101 -> o_err_pos=13, o_ue=1, o_data=0x00.
- Double error: i_data=0x03 (positions 3,5) -> o_err_pos=6, o_ue=1, o_data=0x03 uncorrected; o_cnt_ue increments by 1.
- Backpressure:
  - Stream 6 back-to-back beats, data 0x01..0x06 in valid codewords; hold i_ready=0 for cycles 3-6.
  - Required: o_ready drops once both stages are full, S2 outputs stay stable, and all 6 beats exit in order with no loss.
- Counters with CNT_W=2:
  - 5 CE beats -> o_cnt_ce saturates at 3.
  - i_cnt_clr together with a CE beat entering S2 -> o_cnt_ce=0.
  - Reset asserted with 2 beats in flight -> o_valid=0 and counters=0 the next cycle.
